// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, runs the core until
// it reports done, then streams a window of data memory back out.
//
// Optional feature: define LOADER_TIMEOUT_EN to add a RUN watchdog of TO_W bits.
// Without it the timeout output is tied low and RUN waits for core_done.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   s_valid/s_data/s_last/s_ready   instruction stream in
//   im_we/im_addr/im_wdata          instruction memory write port
//   core_reset, core_done           processor control
//   dm_addr, dm_rdata               data memory read port (combinational read)
//   dump_base, dump_len             dump window, latched when the core starts
//   m_valid/m_data/m_last/m_ready   result stream out
//   restart, finished, ovf, timeout, load_cnt   status / control
module prog_loader #(
  parameter int unsigned IW   = 9,
  parameter int unsigned PC_W = 10,
  parameter int unsigned DW   = 8,
  parameter int unsigned DA_W = 8,
  parameter int unsigned TO_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  input  logic [IW-1:0]   s_data,
  input  logic            s_last,
  output logic            s_ready,
  output logic            im_we,
  output logic [PC_W-1:0] im_addr,
  output logic [IW-1:0]   im_wdata,
  output logic            core_reset,
  input  logic            core_done,
  output logic [DA_W-1:0] dm_addr,
  input  logic [DW-1:0]   dm_rdata,
  input  logic [DA_W-1:0] dump_base,
  input  logic [DA_W:0]   dump_len,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  input  logic            m_ready,
  input  logic            restart,
  output logic            finished,
  output logic            ovf,
  output logic            timeout,
  output logic [PC_W:0]   load_cnt
);

  localparam int unsigned LC_W = PC_W + 1;
  localparam int unsigned RM_W = DA_W + 1;

  // Reject degenerate widths at elaboration.
  if (IW == 0 || PC_W == 0 || DW == 0 || DA_W == 0 || TO_W == 0) begin : g_param_check
    $error("prog_loader: all width parameters must be nonzero");
  end

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   wptr, wptr_nxt;
  logic [LC_W-1:0]   cnt_q, cnt_nxt;
  logic [DA_W-1:0]   rptr, rptr_nxt;
  logic [RM_W-1:0]   rem, rem_nxt;
  logic              ovf_q, ovf_nxt;
  logic              accept;

`ifdef LOADER_TIMEOUT_EN
  logic [TO_W-1:0]   tcnt, tcnt_nxt;
  logic              tout_q, tout_nxt;
  assign timeout = tout_q;
`else
  assign timeout = 1'b0;
`endif

  assign load_cnt = cnt_q;
  assign ovf      = ovf_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
      wptr  <= '0;
      cnt_q <= '0;
      rptr  <= '0;
      rem   <= '0;
      ovf_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tcnt   <= '0;
      tout_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
      cnt_q <= cnt_nxt;
      rptr  <= rptr_nxt;
      rem   <= rem_nxt;
      ovf_q <= ovf_nxt;
`ifdef LOADER_TIMEOUT_EN
      tcnt   <= tcnt_nxt;
      tout_q <= tout_nxt;
`endif
    end
  end

  // Next-state and state-decoded outputs. The load-side strobes are also
  // masked by reset so nothing is written while reset is held.
  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    cnt_nxt    = cnt_q;
    rptr_nxt   = rptr;
    rem_nxt    = rem;
    ovf_nxt    = ovf_q;
`ifdef LOADER_TIMEOUT_EN
    tcnt_nxt   = tcnt;
    tout_nxt   = tout_q;
`endif
    s_ready    = 1'b0;
    im_we      = 1'b0;
    im_addr    = wptr;
    im_wdata   = s_data;
    core_reset = 1'b1;
    dm_addr    = rptr;
    m_data     = dm_rdata;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    finished   = 1'b0;
    accept     = 1'b0;

    case (state)
      ST_LOAD: begin
        s_ready = ~reset;
        im_we   = s_valid & ~reset;
        accept  = s_valid & ~reset;
        if (accept) begin
          cnt_nxt = cnt_q + LC_W'(1);
          // The top address is the last slot: stop loading instead of wrapping.
          if (wptr == {PC_W{1'b1}}) begin
            ovf_nxt   = ovf_q | ~s_last;
            state_nxt = ST_START;
          end else begin
            wptr_nxt = wptr + PC_W'(1);
            if (s_last) state_nxt = ST_START;
          end
        end
      end

      ST_START: begin
        rptr_nxt  = dump_base;
        rem_nxt   = dump_len;
`ifdef LOADER_TIMEOUT_EN
        tcnt_nxt  = '0;
`endif
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        core_reset = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        tcnt_nxt = tcnt + TO_W'(1);
`endif
        if (core_done) begin
          state_nxt = ST_DUMP;
`ifdef LOADER_TIMEOUT_EN
        end else if (tcnt == {TO_W{1'b1}}) begin
          tout_nxt  = 1'b1;
          state_nxt = ST_DONE;
`endif
        end
      end

      ST_DUMP: begin
        core_reset = 1'b0;
        m_valid    = (rem != '0);
        m_last     = (rem == RM_W'(1));
        if (rem == '0) begin
          state_nxt = ST_DONE;
        end else if (m_ready) begin
          rptr_nxt = rptr + DA_W'(1);
          rem_nxt  = rem - RM_W'(1);
          if (m_last) state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        finished = 1'b1;
        if (restart) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
`ifdef LOADER_TIMEOUT_EN
          tout_nxt  = 1'b0;
`endif
        end
      end

      default: state_nxt = ST_LOAD;
    endcase
  end

endmodule
